// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared sizes, FSM and scan-result types for the keypad scanner
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int CODE_W   = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } result_t;

    function automatic logic [CODE_W-1:0] make_code(input logic [1:0] row_idx,
                                                    input logic [1:0] col_idx);
        return {row_idx, col_idx};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a bus of independent asynchronous bits
module sync_2ff #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Rows idle high, so resetting to ones avoids a phantom press after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 scanned keypad reader, per-scan debounce; auto-repeat under KEYPAD_REPEAT_EN
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 20,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                key_down,
    output logic                overrun
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int RW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
`ifdef KEYPAD_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic [TW-1:0]       timer;
    logic [1:0]          col_idx;
    logic                tick;
    logic                scan_done;
    logic [NUM_ROWS-1:0] row_s;
    logic [NUM_ROWS-1:0] row_low;
    logic [2:0]          col_hits;
    logic [2:0]          total_hits;
    logic [1:0]          col_row;
    logic [1:0]          acc_hits;
    logic [1:0]          new_hits;
    logic [CODE_W-1:0]   acc_code;
    logic [CODE_W-1:0]   new_code;
    result_t             result;

    state_t              state;
    state_t              state_next;
    logic [7:0]          cnt;
    logic [7:0]          cnt_next;
    logic [CODE_W-1:0]   cand;
    logic [CODE_W-1:0]   cand_next;
    logic [RW-1:0]       rep_cnt;
    logic [RW-1:0]       rep_next;
    logic                rep_armed;
    logic                rep_armed_next;
    logic                emit;

    sync_2ff #(.WIDTH(NUM_ROWS)) u_row_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (row),
        .q       (row_s)
    );

    assign tick      = (timer == TW'(SCAN_DIV - 1));
    assign scan_done = tick && (col_idx == 2'd3);
    assign col       = ~(4'b0001 << col_idx);
    assign row_low   = ~row_s;
    assign key_down  = (state == HELD) || (state == RELEASE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer   <= '0;
            col_idx <= 2'd0;
        end else if (tick) begin
            timer   <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            timer   <= timer + TW'(1);
        end
    end

    // Hit count saturates at 2: anything beyond one pressed contact is MULTI.
    always_comb begin
        col_hits = 3'd0;
        col_row  = 2'd0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (row_low[r]) begin
                col_hits = col_hits + 3'd1;
                col_row  = 2'(r);
            end
        end
        total_hits = {1'b0, acc_hits} + col_hits;
        new_hits   = (total_hits >= 3'd2) ? 2'd2 : total_hits[1:0];
        new_code   = (acc_hits == 2'd0 && col_hits == 3'd1) ? make_code(col_row, col_idx) : acc_code;
        case (new_hits)
            2'd0:    result = NONE;
            2'd1:    result = SINGLE;
            default: result = MULTI;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_hits <= 2'd0;
            acc_code <= '0;
        end else if (scan_done) begin
            acc_hits <= 2'd0;
            acc_code <= '0;
        end else if (tick) begin
            acc_hits <= new_hits;
            acc_code <= new_code;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        cand_next      = cand;
        rep_next       = rep_cnt;
        rep_armed_next = rep_armed;
        emit           = 1'b0;
        if (scan_done) begin
            case (state)
                SCAN: begin
                    if (result == SINGLE) begin
                        cand_next = new_code;
                        cnt_next  = 8'd1;
                        if (DEBOUNCE_SCANS == 1) begin
                            emit       = 1'b1;
                            state_next = HELD;
                        end else begin
                            state_next = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (result == SINGLE && new_code == cand) begin
                        cnt_next = cnt + 8'd1;
                        if (cnt_next == 8'(DEBOUNCE_SCANS)) begin
                            emit       = 1'b1;
                            state_next = HELD;
                        end
                    end else begin
                        state_next = SCAN;
                    end
                end
                HELD: begin
                    if (result == NONE) begin
                        cnt_next   = 8'd1;
                        state_next = (DEBOUNCE_SCANS == 1) ? SCAN : RELEASE;
                    end else if (REPEAT_ON && result == SINGLE && new_code == cand) begin
                        rep_next = rep_cnt + RW'(1);
                        if (rep_next == (rep_armed ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY))) begin
                            emit           = 1'b1;
                            rep_next       = '0;
                            rep_armed_next = 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    if (result == NONE) begin
                        cnt_next = cnt + 8'd1;
                        if (cnt_next == 8'(DEBOUNCE_SCANS)) begin
                            state_next = SCAN;
                        end
                    end else begin
                        state_next = HELD;
                    end
                end
                default: state_next = SCAN;
            endcase
            if (state_next != HELD) begin
                rep_next       = '0;
                rep_armed_next = 1'b0;
            end
        end
    end

    // An emit while a key is still pending is dropped, even on the transfer cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SCAN;
            cnt       <= 8'd0;
            cand      <= '0;
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            cand      <= cand_next;
            rep_cnt   <= rep_next;
            rep_armed <= rep_armed_next;
            if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
            if (emit) begin
                if (key_valid) begin
                    overrun <= 1'b1;
                end else begin
                    key_valid <= 1'b1;
                    key_code  <= cand_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized and directed bench for keypad_scanner with a scan-level reference model
module tb_keypad_scanner;

    localparam int SD       = 4;
    localparam int DS       = 3;
    localparam int RD       = 4;
    localparam int RR       = 2;
    localparam int SCAN_CYC = SD * 4;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b1;
    logic       key_down;
    logic       overrun;

    logic [15:0] keys = '0;
    int ready_mode = 1;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    bit m_valid = 0;
    bit m_old_valid = 0;
    int m_code = 0;
    bit m_over = 0;
    bit m_held = 0;
    int m_cand = 0;
    int m_run = 0;
    int m_quiet = 0;
    int m_rep = 0;
    bit m_rep_armed = 0;
    int m_emits = 0;

    int xfers = 0;
    int last_xfer = 0;

    keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DS),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_down  (key_down),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Pressed key (r,c) pulls row r low while column c is strobed.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc = 0; m_valid = 0; m_code = 0; m_over = 0; m_held = 0;
        m_cand = 0; m_run = 0; m_quiet = 0; m_rep = 0; m_rep_armed = 0;
    endtask

    task automatic model_emit(input int c);
        m_emits++;
        if (m_old_valid) m_over = 1;
        else begin
            m_valid = 1;
            m_code  = c;
        end
    endtask

    // One full scan, judged from the key mask that was held for the whole scan.
    task automatic model_scan();
        int pop;
        int code;
        bit single;
        pop = $countones(keys);
        code = 0;
        for (int i = 0; i < 16; i++) if (keys[i]) code = i;
        single = (pop == 1);
        if (!m_held) begin
            if (single && m_run > 0 && code == m_cand) m_run++;
            else if (single && m_run == 0) begin
                m_cand = code;
                m_run = 1;
            end else m_run = 0;
            if (m_run == DS) begin
                model_emit(m_cand);
                m_held = 1; m_run = 0; m_quiet = 0; m_rep = 0; m_rep_armed = 0;
            end
        end else if (pop == 0) begin
            m_rep = 0;
            m_rep_armed = 0;
            m_quiet++;
            if (m_quiet == DS) begin
                m_held = 0;
                m_quiet = 0;
            end
        end else begin
            m_quiet = 0;
`ifdef KEYPAD_REPEAT_EN
            if (single && code == m_cand) begin
                m_rep++;
                if (m_rep == (m_rep_armed ? RR : RD)) begin
                    model_emit(m_cand);
                    m_rep = 0;
                    m_rep_armed = 1;
                end
            end
`endif
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) model_reset();
        else begin
            m_old_valid = m_valid;
            if (m_valid && key_ready) m_valid = 0;
            cyc++;
            if (cyc % SCAN_CYC == 0) model_scan();
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            check("col", int'(col), int'(4'hF & ~(4'b0001 << ((cyc / SD) % 4))));
            check("key_valid", int'(key_valid), int'(m_valid));
            check("key_code", int'(key_code), m_code);
            check("key_down", int'(key_down), int'(m_held));
            check("overrun", int'(overrun), int'(m_over));
            if (key_valid && key_ready) begin
                xfers++;
                last_xfer = int'(key_code);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0:       key_ready = 1'b0;
            1:       key_ready = 1'b1;
            default: key_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic run_scans(input logic [15:0] m, input int n);
        int g;
        g = 0;
        while (cyc % SCAN_CYC != 0 && g < 64) begin
            @(posedge clk);
            #2;
            g++;
        end
        if (g >= 64) check("scan_align_timeout", g, 0);
        keys = m;
        repeat (n * SCAN_CYC) @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0]  col_seq [4];
        logic [15:0] m;
        int x0;
        int e0;
        int p;
        int exp_rep;
        col_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        repeat (3) @(posedge clk);
        #2;
        check("reset_col", int'(col), 4'b1110);
        check("reset_valid", int'(key_valid), 0);
        reset_n = 1'b1;

        // Single clean press of code 9.
        x0 = xfers; e0 = m_emits;
        run_scans(16'(1) << 9, 3);
        check("t2_valid", int'(key_valid), 1);
        check("t2_code", int'(key_code), 9);
        check("t2_down", int'(key_down), 1);
        run_scans(16'h0, 3);
        check("t2_released", int'(key_down), 0);
        check("t2_xfers", xfers - x0, 1);
        check("t2_last", last_xfer, 9);
        check("t2_model_emits", m_emits - e0, 1);

        // Bounce on code 3.
        x0 = xfers;
        run_scans(16'(1) << 3, 1);
        run_scans(16'h0, 1);
        run_scans(16'(1) << 3, 2);
        check("t3_no_early", int'(key_valid), 0);
        run_scans(16'(1) << 3, 1);
        check("t3_valid", int'(key_valid), 1);
        check("t3_code", int'(key_code), 3);
        run_scans(16'h0, 3);
        check("t3_xfers", xfers - x0, 1);

        // Codes 0 and 5 together never qualify.
        x0 = xfers;
        run_scans((16'(1) << 0) | (16'(1) << 5), 5);
        check("t4_valid", int'(key_valid), 0);
        check("t4_down", int'(key_down), 0);
        check("t4_xfers", xfers - x0, 0);
        run_scans(16'h0, 1);

        // Backpressure: 7 pending, 12 lost.
        ready_mode = 0;
        x0 = xfers;
        run_scans(16'(1) << 7, 3);
        run_scans(16'h0, 3);
        run_scans(16'(1) << 12, 3);
        check("t5_valid", int'(key_valid), 1);
        check("t5_code", int'(key_code), 7);
        check("t5_overrun", int'(overrun), 1);
        check("t5_model_over", int'(m_over), 1);
        ready_mode = 1;
        run_scans(16'h0, 3);
        check("t5_xfers", xfers - x0, 1);
        check("t5_last", last_xfer, 7);
        check("t5_overrun_sticky", int'(overrun), 1);

        // Asynchronous reset with a key pending.
        ready_mode = 0;
        run_scans(16'(1) << 9, 3);
        keys = '0;
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("t1_col", int'(col), 4'b1110);
        check("t1_valid", int'(key_valid), 0);
        check("t1_down", int'(key_down), 0);
        check("t1_overrun", int'(overrun), 0);
        check("t1_code", int'(key_code), 0);
        ready_mode = 1;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t1_col_step", int'(col), int'(col_seq[k]));
            repeat (SD) @(posedge clk);
            #2;
        end

        // Long hold of code 15.
`ifdef KEYPAD_REPEAT_EN
        exp_rep = 4;
`else
        exp_rep = 1;
`endif
        x0 = xfers; e0 = m_emits;
        run_scans(16'(1) << 15, 12);
        run_scans(16'h0, 3);
        check("t6_xfers", xfers - x0, exp_rep);
        check("t6_model_emits", m_emits - e0, exp_rep);
        check("t6_last", last_xfer, 15);

        // Random key patterns with random backpressure.
        ready_mode = 2;
        m = '0;
        for (int s = 0; s < 60; s++) begin
            p = $urandom_range(0, 99);
            if (p < 20) m = '0;
            else if (p < 45) m = 16'(1) << $urandom_range(0, 15);
            else if (p < 55) m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            run_scans(m, $urandom_range(1, 4));
        end
        run_scans(16'h0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
